// File: rtl/layer_4_frame_scheduler_pkg.sv
// Shared definitions for the layer_N frame schedulers: FSM state encoding,
// coordinate / feature-map index widths and a window-position helper.
package layer_4_frame_scheduler_pkg;

    // Pixel coordinates are 10 bits wide so images up to 1024x1024 fit
    // without the counters ever wrapping on their own.
    localparam int COORD_W = 10;
    localparam int FMAP_W  = 8;
    localparam int DRAIN_W = 8;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [FMAP_W-1:0]  fmap_t;
    typedef logic [DRAIN_W-1:0] drain_t;

    // Scheduler phases for one layer pass.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    // A pixel at (row, col) closes a full 3x3 window once two complete
    // rows and two complete columns precede it.
    function automatic logic is_window_pos(input coord_t row, input coord_t col);
        return (row >= coord_t'(2)) && (col >= coord_t'(2));
    endfunction

endpackage

// File: rtl/layer_4_frame_scheduler_frame_pixel_counter.sv
// Raster-order row/column counter for one frame. Advances one pixel per
// enabled cycle, wraps col at the end of a row and both at the end of the
// frame; 'last' flags the final pixel of the frame.
module frame_pixel_counter
    import layer_4_frame_scheduler_pkg::*;
#(
    parameter int IMG_SIZE = 104
) (
    input  logic   Clk,
    input  logic   Rst,
    input  logic   clear,
    input  logic   enable,
    output coord_t row,
    output coord_t col,
    output logic   last
);

    // Largest coordinate value; counters compare against this only.
    localparam coord_t MAX_COORD = coord_t'(IMG_SIZE - 1);

    // Coordinate registers: clear has priority over a pixel advance.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (enable) begin
            if (col == MAX_COORD) begin
                col <= '0;
                row <= (row == MAX_COORD) ? '0 : row + coord_t'(1);
            end else begin
                col <= col + coord_t'(1);
            end
        end
    end

    // Final pixel of the frame is at the bottom-right corner.
    always_comb begin
        last = (row == MAX_COORD) && (col == MAX_COORD);
    end

endmodule

// File: rtl/layer_4_frame_scheduler.sv
// Frame scheduler for convolution layer 4. A single start launches a pass
// that streams one full IMG_SIZE x IMG_SIZE frame into the Conv2D3x3 bank
// for every output feature map, flushing the bank pipeline between maps.
//
// Handshake: a pixel transfer happens on a rising edge where
// src_valid & src_ready are both 1. src_ready depends only on the
// scheduler state (never on src_valid), and src_valid may be dropped at any
// time; while it is low the scheduler simply waits with no timeout.
module layer_4_frame_scheduler
    import layer_4_frame_scheduler_pkg::*;
#(
    parameter int IMG_SIZE     = 104,
    parameter int NUM_FMAPS    = 16,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         start,
    input  logic         src_valid,
    output logic         src_ready,
    output logic         conv_valid_in,
    output logic         win_valid,
    output fmap_t        fmap_idx,
    output coord_t       row,
    output coord_t       col,
    output logic         busy,
    output logic         done,
    output sched_state_t state_dbg
);

    localparam fmap_t  LAST_FMAP  = fmap_t'(NUM_FMAPS - 1);
    localparam drain_t DRAIN_LOAD = drain_t'(DRAIN_CYCLES);

    sched_state_t state;
    drain_t       drain_cnt;
    logic         xfer;
    logic         frame_last;
    logic         cnt_clear;

    // Transfer strobe; also the zero-latency valid into the conv bank.
    always_comb begin
        xfer          = src_valid && src_ready;
        conv_valid_in = xfer;
        win_valid     = xfer && is_window_pos(row, col);
        cnt_clear     = (state == ST_IDLE) && start;
    end

    frame_pixel_counter #(
        .IMG_SIZE (IMG_SIZE)
    ) u_pixel_counter (
        .Clk    (Clk),
        .Rst    (Rst),
        .clear  (cnt_clear),
        .enable (xfer),
        .row    (row),
        .col    (col),
        .last   (frame_last)
    );

    // Pass sequencer: state, feature-map index, drain counter and the
    // state-decoded status outputs, all registered together.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= ST_IDLE;
            fmap_idx  <= '0;
            drain_cnt <= '0;
            src_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_FEED;
                        fmap_idx  <= '0;
                        src_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_FEED: begin
                    if (xfer && frame_last) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                        src_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // drain_cnt counts remaining flush cycles including this one.
                    if (drain_cnt <= drain_t'(1)) begin
                        state     <= ST_NEXT;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - drain_t'(1);
                    end
                end
                ST_NEXT: begin
                    if (fmap_idx == LAST_FMAP) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= ST_FEED;
                        fmap_idx  <= fmap_idx + fmap_t'(1);
                        src_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // fmap_idx keeps its final value until the next start.
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    src_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // Debug view of the sequencer state.
    always_comb begin
        state_dbg = state;
    end

endmodule

// File: tb/tb_layer_4_frame_scheduler.sv
// Bench for layer_4_frame_scheduler with IMG_SIZE=4, DRAIN_CYCLES=3.
// Two instances share clock, reset and src_valid: dut2 runs NUM_FMAPS=2,
// dut1 runs NUM_FMAPS=1; 'sel' chooses which one gets start and is observed.
module tb_layer_4_frame_scheduler;
    import layer_4_frame_scheduler_pkg::*;

    localparam int IMG   = 4;
    localparam int DRAIN = 3;
    localparam int W     = FMAP_W + 2 * COORD_W + 1;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    logic start = 1'b0;
    logic src_valid = 1'b0;
    logic sel = 1'b0;

    logic         a_ready, a_cvi, a_win, a_busy, a_done;
    fmap_t        a_fmap;
    coord_t       a_row, a_col;
    sched_state_t a_state;
    logic         b_ready, b_cvi, b_win, b_busy, b_done;
    fmap_t        b_fmap;
    coord_t       b_row, b_col;
    sched_state_t b_state;

    layer_4_frame_scheduler #(.IMG_SIZE(IMG), .NUM_FMAPS(2), .DRAIN_CYCLES(DRAIN)) dut2 (
        .Clk(Clk), .Rst(Rst), .start(start && !sel), .src_valid(src_valid),
        .src_ready(a_ready), .conv_valid_in(a_cvi), .win_valid(a_win),
        .fmap_idx(a_fmap), .row(a_row), .col(a_col), .busy(a_busy),
        .done(a_done), .state_dbg(a_state)
    );

    layer_4_frame_scheduler #(.IMG_SIZE(IMG), .NUM_FMAPS(1), .DRAIN_CYCLES(DRAIN)) dut1 (
        .Clk(Clk), .Rst(Rst), .start(start && sel), .src_valid(src_valid),
        .src_ready(b_ready), .conv_valid_in(b_cvi), .win_valid(b_win),
        .fmap_idx(b_fmap), .row(b_row), .col(b_col), .busy(b_busy),
        .done(b_done), .state_dbg(b_state)
    );

    logic         o_ready, o_cvi, o_win, o_busy, o_done;
    fmap_t        o_fmap;
    coord_t       o_row, o_col;
    sched_state_t o_state;

    always_comb begin
        o_ready = sel ? b_ready : a_ready;
        o_cvi   = sel ? b_cvi   : a_cvi;
        o_win   = sel ? b_win   : a_win;
        o_busy  = sel ? b_busy  : a_busy;
        o_done  = sel ? b_done  : a_done;
        o_fmap  = sel ? b_fmap  : a_fmap;
        o_row   = sel ? b_row   : a_row;
        o_col   = sel ? b_col   : a_col;
        o_state = sel ? b_state : a_state;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet_idle(input string tag);
        check({tag, "_busy"},  32'(o_busy), 0);
        check({tag, "_done"},  32'(o_done), 0);
        check({tag, "_ready"}, 32'(o_ready), 0);
        check({tag, "_cvi"},   32'(o_cvi), 0);
        check({tag, "_win"},   32'(o_win), 0);
        check({tag, "_state"}, 32'(o_state), 32'(ST_IDLE));
    endtask

    // Expected transfer list of one frame: raster order, window flag set
    // when two full rows and two full columns precede the pixel.
    task automatic load_frame(input int f);
        exp_q.delete();
        for (int k = 0; k < IMG * IMG; k++) begin
            int r;
            int c;
            r = k / IMG;
            c = k % IMG;
            exp_q.push_back({fmap_t'(f), coord_t'(r), coord_t'(c), (r >= 2 && c >= 2) ? 1'b1 : 1'b0});
        end
    endtask

    // ---------------- driver ----------------
    // mode 0: src_valid held 1; mode 1: toggled; mode 2: random.
    // Called aligned at posedge+1; returns aligned at posedge+1.
    task automatic run_pass(input int nf, input int mode, input bit poke_start);
        logic [W-1:0] exp;
        bit v;
        int phase;
        int stalls;
        int wins;
        start = 1'b1;
        src_valid = 1'b0;
        @(negedge Clk);
        check("pre_busy", 32'(o_busy), 0);
        @(posedge Clk); #1;
        start = 1'b0;
        for (int f = 0; f < nf; f++) begin
            load_frame(f);
            phase = 0;
            stalls = 0;
            wins = 0;
            while (exp_q.size() > 0) begin
                case (mode)
                    0: v = 1'b1;
                    1: v = phase[0];
                    default: v = ($urandom_range(0, 3) != 0);
                endcase
                if (stalls >= 6) v = 1'b1;
                src_valid = v;
                start = poke_start && ($urandom_range(0, 3) == 0);
                @(negedge Clk);
                exp = exp_q[0];
                check("feed_ready", 32'(o_ready), 1);
                check("feed_busy", 32'(o_busy), 1);
                check("feed_done", 32'(o_done), 0);
                check("feed_cvi", 32'(o_cvi), 32'(v));
                check("feed_fmap", 32'(o_fmap), 32'(exp[W-1 -: FMAP_W]));
                check("feed_row", 32'(o_row), 32'(exp[2*COORD_W -: COORD_W]));
                check("feed_col", 32'(o_col), 32'(exp[COORD_W -: COORD_W]));
                if (v) begin
                    check("feed_win", 32'(o_win), 32'(exp[0]));
                    if (o_win) wins++;
                    void'(exp_q.pop_front());
                    stalls = 0;
                end else begin
                    check("stall_win", 32'(o_win), 0);
                    stalls++;
                end
                phase++;
                @(posedge Clk); #1;
            end
            check("win_count", 32'(wins), 4);
            // DRAIN_CYCLES flush cycles followed by one NEXT cycle.
            for (int d = 0; d <= DRAIN; d++) begin
                src_valid = ($urandom_range(0, 1) == 1);
                start = poke_start && ($urandom_range(0, 1) == 1);
                @(negedge Clk);
                check("drain_ready", 32'(o_ready), 0);
                check("drain_cvi", 32'(o_cvi), 0);
                check("drain_win", 32'(o_win), 0);
                check("drain_busy", 32'(o_busy), 1);
                check("drain_done", 32'(o_done), 0);
                check("drain_fmap", 32'(o_fmap), 32'(f));
                check("drain_row", 32'(o_row), 0);
                check("drain_col", 32'(o_col), 0);
                check("drain_state", 32'(o_state), (d < DRAIN) ? 32'(ST_DRAIN) : 32'(ST_NEXT));
                @(posedge Clk); #1;
            end
        end
        start = 1'b0;
        src_valid = 1'b0;
        @(negedge Clk);
        check("done_pulse", 32'(o_done), 1);
        check("done_busy", 32'(o_busy), 1);
        check("done_fmap", 32'(o_fmap), 32'(nf - 1));
        check("done_ready", 32'(o_ready), 0);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("after_done", 32'(o_done), 0);
        check("after_busy", 32'(o_busy), 0);
        check("after_fmap_hold", 32'(o_fmap), 32'(nf - 1));
        check("after_state", 32'(o_state), 32'(ST_IDLE));
        @(posedge Clk); #1;
    endtask

    // Reset asserted at row=2, col=1, fmap=1 together with a start pulse.
    task automatic reset_mid_frame();
        sel = 1'b0;
        start = 1'b1;
        src_valid = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        // 16 transfers + 3 drain + 1 next + 9 transfers into the second frame.
        for (int i = 0; i < IMG * IMG + DRAIN + 1 + 2 * IMG + 1; i++) begin
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        check("mid_row", 32'(o_row), 2);
        check("mid_col", 32'(o_col), 1);
        check("mid_fmap", 32'(o_fmap), 1);
        Rst = 1'b0;
        start = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b1;
        start = 1'b0;
        @(negedge Clk);
        check_quiet_idle("rst_mid");
        check("rst_mid_row", 32'(o_row), 0);
        check("rst_mid_col", 32'(o_col), 0);
        check("rst_mid_fmap", 32'(o_fmap), 0);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("rst_start_ignored", 32'(o_busy), 0);
        @(posedge Clk); #1;
        src_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        Rst = 1'b0;
        start = 1'b1;
        src_valid = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        @(negedge Clk);
        check_quiet_idle("reset");
        check("reset_fmap", 32'(o_fmap), 0);
        check("reset_row", 32'(o_row), 0);
        check("reset_col", 32'(o_col), 0);
        @(posedge Clk); #1;
        Rst = 1'b1;
        start = 1'b0;
        src_valid = 1'b0;
        @(posedge Clk); #1;

        sel = 1'b0;
        run_pass(2, 0, 1'b0);
        run_pass(2, 1, 1'b0);
        run_pass(2, 2, 1'b1);
        reset_mid_frame();
        run_pass(2, 0, 1'b1);

        sel = 1'b1;
        run_pass(1, 0, 1'b0);
        run_pass(1, 2, 1'b1);

        sel = 1'b0;
        for (int i = 0; i < 2; i++) run_pass(2, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
